// File: rtl/pusch_cw_pkg.sv
// Shared definitions for the PUSCH codeword selection path.
// Holds the default geometry of the codeword tables, the row/index types
// and the beam selector FSM encoding.
package pusch_cw_pkg;

    localparam int CW_ANTS  = 32;   // antennas per codeword row
    localparam int CW_WIDTH = 32;   // bits per antenna coefficient
    localparam int CW_DEPTH = 64;   // rows per table (even and odd)
    localparam int CW_BEAMS = 16;   // beams per group
    localparam int CW_IDXW  = 8;    // beam index width

    typedef logic [CW_WIDTH*CW_ANTS-1:0] cw_row_t;
    typedef logic [CW_IDXW-1:0]          beam_idx_t;

    typedef enum logic {
        WAIT_TBL = 1'b0,
        RUN      = 1'b1
    } cw_state_e;

endpackage

// File: rtl/cw_sel_fifo2.sv
// 2-entry first-word-fall-through FIFO with registered head output.
// Latency: a push into an empty FIFO is visible at the output next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
//
// Ports:
//   i_clk, i_reset_n       clock, async active-low reset
//   i_push, i_push_dat     write strobe and payload
//   i_pop                  consume head (ignored when empty)
//   o_pop_dat              head payload, driven straight from a register
//   o_count, o_full, o_empty  occupancy
module cw_sel_fifo2 #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_dat,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   cnt_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = i_pop && (cnt_q != 2'd0);
    assign do_push = i_push && ((cnt_q != 2'd2) || do_pop);

    // Head is always entry 0 so the output is a plain register; the tail
    // shifts into the head when the head is consumed with two stored.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (do_push) begin
                        head_q <= i_push_dat;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (do_push && do_pop) begin
                        head_q <= i_push_dat;
                    end else if (do_push) begin
                        tail_q <= i_push_dat;
                        cnt_q  <= 2'd2;
                    end else if (do_pop) begin
                        cnt_q  <= 2'd0;
                    end
                end
                default: begin
                    if (do_pop) begin
                        head_q <= tail_q;
                        if (do_push) begin
                            tail_q <= i_push_dat;
                        end else begin
                            cnt_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_pop_dat = head_q;
    assign o_count   = cnt_q;
    assign o_full    = (cnt_q == 2'd2);
    assign o_empty   = (cnt_q == 2'd0);

endmodule

// File: rtl/beam_cw_select.sv
// Maps sorted beam indices to codeword rows from the even/odd tables and tags group ends.
// Latency: 1 cycle from request accept to o_cw_vld with the selected row.
// Backpressure: o_beam_rdy drops when the 2-entry output buffer is full or tables are not valid.
//
// Ports:
//   i_clk, i_reset_n            clock, async active-low reset
//   i_cw_even, i_cw_odd         static codeword tables, DEPTH rows each
//   i_tbl_vld                   tables usable while high
//   i_beam_idx/_vld, o_beam_rdy request stream (idx[0] picks table, idx>>1 picks row)
//   o_cw_data/_idx/_last/_vld, i_cw_rdy  codeword output stream
//   o_err                       sticky: an out-of-range index was dropped
module beam_cw_select
    import pusch_cw_pkg::*;
#(
    parameter int ANTS  = CW_ANTS,
    parameter int WIDTH = CW_WIDTH,
    parameter int DEPTH = CW_DEPTH,
    parameter int BEAMS = CW_BEAMS,
    parameter int IDXW  = CW_IDXW
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic [DEPTH-1:0][WIDTH*ANTS-1:0]  i_cw_even,
    input  logic [DEPTH-1:0][WIDTH*ANTS-1:0]  i_cw_odd,
    input  logic                              i_tbl_vld,
    input  logic [IDXW-1:0]                   i_beam_idx,
    input  logic                              i_beam_vld,
    output logic                              o_beam_rdy,
    output logic [WIDTH*ANTS-1:0]             o_cw_data,
    output logic [IDXW-1:0]                   o_cw_idx,
    output logic                              o_cw_last,
    output logic                              o_cw_vld,
    input  logic                              i_cw_rdy,
    output logic                              o_err
);

    localparam int ROW_W = WIDTH * ANTS;
    localparam int ROWW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GRPW  = (BEAMS > 1) ? $clog2(BEAMS) : 1;
    localparam int PAY_W = ROW_W + IDXW + 1;

    localparam logic [IDXW:0]   IDX_LIM  = (IDXW+1)'(2 * DEPTH);
    localparam logic [GRPW-1:0] GRP_LAST = GRPW'(BEAMS - 1);

    cw_state_e        state_q;
    logic [GRPW-1:0]  grp_cnt_q;
    logic             err_q;

    logic             accept;
    logic             in_range;
    logic             push;
    logic             grp_last;
    logic             leave_run;
    logic [ROWW-1:0]  row_sel;
    logic [ROW_W-1:0] row_data;

    logic [PAY_W-1:0] fifo_din;
    logic [PAY_W-1:0] fifo_dout;
    logic [1:0]       fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty_unused;

    // ------------------------------------------------------------------
    // Table-valid FSM: follows i_tbl_vld one edge late.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= WAIT_TBL;
        end else begin
            state_q <= i_tbl_vld ? RUN : WAIT_TBL;
        end
    end

    assign leave_run = (state_q == RUN) && !i_tbl_vld;

    // Depends only on registered state, never on i_cw_rdy.
    assign o_beam_rdy = (state_q == RUN) && !fifo_full;
    assign accept     = i_beam_vld && o_beam_rdy;

    // ------------------------------------------------------------------
    // Index decode. The range check guarantees the upper index bits above
    // the row field are zero, so only the row field addresses the table.
    // ------------------------------------------------------------------
    assign in_range = ({1'b0, i_beam_idx} < IDX_LIM);
    assign row_sel  = i_beam_idx[ROWW:1];
    assign row_data = i_beam_idx[0] ? i_cw_odd[row_sel] : i_cw_even[row_sel];
    assign push     = accept && in_range;

    // ------------------------------------------------------------------
    // Group counter: counts only beams that reach the output buffer.
    // A table reload restarts the group; that clear wins over a
    // same-edge accept so the new table starts a fresh group.
    // ------------------------------------------------------------------
    assign grp_last = (grp_cnt_q == GRP_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grp_cnt_q <= '0;
        end else if (leave_run) begin
            grp_cnt_q <= '0;
        end else if (push) begin
            grp_cnt_q <= grp_last ? '0 : grp_cnt_q + GRPW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_q <= 1'b0;
        end else if (accept && !in_range) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;

    // ------------------------------------------------------------------
    // Output buffer. Row data is captured at accept time, so entries stay
    // intact across a table reload and drain normally.
    // ------------------------------------------------------------------
    assign fifo_din = {row_data, i_beam_idx, grp_last};

    cw_sel_fifo2 #(
        .W (PAY_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_push     (push),
        .i_push_dat (fifo_din),
        .i_pop      (i_cw_rdy),
        .o_pop_dat  (fifo_dout),
        .o_count    (fifo_cnt),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty_unused)
    );

    assign o_cw_vld = (fifo_cnt != 2'd0);
    assign {o_cw_data, o_cw_idx, o_cw_last} = fifo_dout;

endmodule

// File: tb/tb_beam_cw_select.sv
// Scoreboard bench for beam_cw_select: directed beam streams, stalls,
// out-of-range drop, table reload and asynchronous reset mid-drain.
module tb_beam_cw_select;
    import pusch_cw_pkg::*;

    localparam int ANTS  = 32;
    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int BEAMS = 16;
    localparam int IDXW  = 8;
    localparam int ROW_W = WIDTH * ANTS;

    logic                        i_clk = 1'b0;
    logic                        i_reset_n = 1'b0;
    logic [DEPTH-1:0][ROW_W-1:0] cw_even;
    logic [DEPTH-1:0][ROW_W-1:0] cw_odd;
    logic                        i_tbl_vld = 1'b0;
    beam_idx_t                   i_beam_idx = '0;
    logic                        i_beam_vld = 1'b0;
    logic                        o_beam_rdy;
    cw_row_t                     o_cw_data;
    beam_idx_t                   o_cw_idx;
    logic                        o_cw_last;
    logic                        o_cw_vld;
    logic                        i_cw_rdy = 1'b1;
    logic                        o_err;

    beam_cw_select #(
        .ANTS (ANTS), .WIDTH (WIDTH), .DEPTH (DEPTH), .BEAMS (BEAMS), .IDXW (IDXW)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_cw_even  (cw_even),
        .i_cw_odd   (cw_odd),
        .i_tbl_vld  (i_tbl_vld),
        .i_beam_idx (i_beam_idx),
        .i_beam_vld (i_beam_vld),
        .o_beam_rdy (o_beam_rdy),
        .o_cw_data  (o_cw_data),
        .o_cw_idx   (o_cw_idx),
        .o_cw_last  (o_cw_last),
        .o_cw_vld   (o_cw_vld),
        .i_cw_rdy   (i_cw_rdy),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        cw_row_t   dat;
        beam_idx_t idx;
        logic      last;
        int        acc;
        bit        lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   grp     = 0;
    bit   chk_lat = 1'b0;
    int   w;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Table contents: each 32-bit coefficient encodes table, row and antenna.
    function automatic cw_row_t mk_row(input bit odd, input int r);
        cw_row_t v;
        for (int a = 0; a < ANTS; a++)
            v[a*WIDTH +: WIDTH] = {(odd ? 8'hD0 : 8'hE0), 8'(r), 16'(a*3 + 1)};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_row(input string name, input cw_row_t act, input cw_row_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int a = 0; a < ANTS; a++) begin
                if (act[a*WIDTH +: WIDTH] !== exp[a*WIDTH +: WIDTH]) begin
                    $display("FAIL %s: word %0d got %h expected %h (t=%0t)", name, a,
                             act[a*WIDTH +: WIDTH], exp[a*WIDTH +: WIDTH], $time);
                    break;
                end
            end
        end
    endtask

    // Issue one request at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input int idx, output int waits);
        exp_t e;
        i_beam_idx = beam_idx_t'(idx);
        i_beam_vld = 1'b1;
        waits = 0;
        for (;;) begin
            @(negedge i_clk);
            if (o_beam_rdy) break;
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: idx %0d not accepted within 50 cycles", idx);
                i_beam_vld = 1'b0;
                return;
            end
        end
        if (idx < 2*DEPTH) begin
            e.dat  = mk_row(idx[0], idx >> 1);
            e.idx  = beam_idx_t'(idx);
            e.last = (grp == BEAMS-1);
            e.acc  = cyc;
            e.lat  = chk_lat;
            sb.push_back(e);
            grp = (grp + 1) % BEAMS;
        end
        @(posedge i_clk);
        #1;
        i_beam_vld = 1'b0;
    endtask

    // Monitor: every output handshake is matched against the scoreboard head.
    always @(negedge i_clk) begin
        if (i_reset_n && o_cw_vld && i_cw_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got idx %0d expected no output", o_cw_idx);
            end else begin
                mon_e = sb.pop_front();
                chk_row("out_data", o_cw_data, mon_e.dat);
                chk("out_idx", 32'(o_cw_idx), 32'(mon_e.idx));
                chk("out_last", 32'(o_cw_last), 32'(mon_e.last));
                if (mon_e.lat) chk("out_latency", cyc - mon_e.acc, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < DEPTH; r++) begin
            cw_even[r] = mk_row(1'b0, r);
            cw_odd[r]  = mk_row(1'b1, r);
        end

        // Reset values, then tables held invalid.
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(negedge i_clk);
        chk("rst_rdy",  32'(o_beam_rdy), 0);
        chk("rst_vld",  32'(o_cw_vld), 0);
        chk("rst_last", 32'(o_cw_last), 0);
        chk("rst_err",  32'(o_err), 0);
        chk("rst_idx",  32'(o_cw_idx), 0);
        chk_row("rst_data", o_cw_data, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            chk("idle_rdy", 32'(o_beam_rdy), 0);
            chk("idle_vld", 32'(o_cw_vld), 0);
        end

        // Tables valid: rdy rises the cycle after i_tbl_vld is sampled.
        @(posedge i_clk);
        #1;
        i_tbl_vld = 1'b1;
        @(negedge i_clk);
        chk("rdy_before_run", 32'(o_beam_rdy), 0);
        @(negedge i_clk);
        chk("rdy_in_run", 32'(o_beam_rdy), 1);
        @(posedge i_clk);
        #1;

        // idx 0..3 back-to-back -> even[0], odd[0], even[1], odd[1].
        chk_lat = 1'b1;
        for (int i = 0; i < 4; i++) send(i, w);

        // Reload restarts the group, then 32 beams: last on #16 and #32.
        i_tbl_vld = 1'b0;
        @(posedge i_clk);
        #1;
        i_tbl_vld = 1'b1;
        @(negedge i_clk);
        chk("rdy_reload", 32'(o_beam_rdy), 0);
        @(posedge i_clk);
        #1;
        grp = 0;
        for (int i = 0; i < 32; i++) send((i*7 + 3) % 128, w);

        // 15 beams, an out-of-range drop, then idx 5 closes the group.
        for (int i = 0; i < 15; i++) send(40 + i, w);
        chk("err_before", 32'(o_err), 0);
        send(130, w);
        @(negedge i_clk);
        chk("err_set", 32'(o_err), 1);
        @(posedge i_clk);
        #1;
        send(5, w);
        repeat (3) @(posedge i_clk);
        #1;

        // Stall: two accepts fill the buffer, the third waits.
        chk_lat = 1'b0;
        i_cw_rdy = 1'b0;
        send(20, w);
        chk("stall_acc1_waits", w, 0);
        send(21, w);
        chk("stall_acc2_waits", w, 0);
        i_beam_idx = 8'd22;
        i_beam_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("stall_rdy", 32'(o_beam_rdy), 0);
            chk("stall_vld", 32'(o_cw_vld), 1);
            chk("stall_idx", 32'(o_cw_idx), 20);
            chk_row("stall_data", o_cw_data, mk_row(1'b0, 10));
        end
        @(posedge i_clk);
        #1;
        i_cw_rdy = 1'b1;
        @(negedge i_clk);
        chk("rdy_before_pop", 32'(o_beam_rdy), 0);
        @(posedge i_clk);
        #1;
        send(22, w);
        chk("stall_acc3_waits", w, 0);
        repeat (3) @(posedge i_clk);
        #1;

        // Buffer two, drop tables, async reset mid-drain.
        i_cw_rdy = 1'b0;
        send(60, w);
        send(61, w);
        i_tbl_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            chk("drain_rdy", 32'(o_beam_rdy), 0);
            chk("drain_vld", 32'(o_cw_vld), 1);
        end
        @(posedge i_clk);
        #1;
        i_cw_rdy = 1'b1;
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_vld",  32'(o_cw_vld), 0);
        chk("arst_rdy",  32'(o_beam_rdy), 0);
        chk("arst_last", 32'(o_cw_last), 0);
        chk("arst_err",  32'(o_err), 0);
        chk("arst_idx",  32'(o_cw_idx), 0);
        chk_row("arst_data", o_cw_data, '0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        grp = 0;
        i_tbl_vld = 1'b1;
        @(posedge i_clk);
        #1;

        // Fresh group after reset: last only on the 16th beam.
        chk_lat = 1'b1;
        for (int i = 0; i < 16; i++) send(i * 5, w);
        repeat (4) @(posedge i_clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
